// File: rtl/seq_mul_32.sv
// rtl/seq_mul_32.sv - iterative 32x32->64 unsigned shift-and-add multiplier with carry-select accumulator

// 64-bit carry-select adder: 16-bit blocks precompute both carry-in cases
// so the block carry chain is just a mux per block.
module csa_64 (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic        c_in_i,
  output logic [63:0] sum_o,
  output logic        c_out_o
);

  localparam int BLK  = 16;
  localparam int NBLK = 4;

  logic [NBLK:0] carry;

  assign carry[0] = c_in_i;

  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    logic [BLK:0] s0;
    logic [BLK:0] s1;

    assign s0 = {1'b0, a_i[g*BLK +: BLK]} + {1'b0, b_i[g*BLK +: BLK]};
    assign s1 = {1'b0, a_i[g*BLK +: BLK]} + {1'b0, b_i[g*BLK +: BLK]} + 17'd1;
    assign sum_o[g*BLK +: BLK] = carry[g] ? s1[BLK-1:0] : s0[BLK-1:0];
    assign carry[g+1]          = carry[g] ? s1[BLK]     : s0[BLK];
  end

  assign c_out_o = carry[NBLK];

endmodule

// Multiplier: accept operands in IDLE, run exactly 32 conditional adds,
// then hold the product in DONE until the consumer takes it.
module seq_mul_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [63:0] acc_q;
  logic [5:0]  cnt_q;

  logic [63:0] sum;
  logic        sum_c_out;
  logic [63:0] acc_d;

  csa_64 u_csa (
    .a_i     (acc_q),
    .b_i     (mcand_q),
    .c_in_i  (1'b0),
    .sum_o   (sum),
    .c_out_o (sum_c_out)
  );

  // Add the shifted multiplicand only when the current multiplier bit is set.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = sum;
    end
  end

  // Handshake flags decode registered state only; no input-to-output path.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = acc_q;

  // Control FSM and datapath registers; reset wins over accept and completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 6'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q  <= {32'd0, a};
            mplier_q <= b;
            acc_q    <= 64'd0;
            cnt_q    <= 6'd0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[62:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[31:1]};
          cnt_q    <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A 32-bit by 32-bit partial sum always fits in 64 bits, so the adder never carries out.
  a_no_carry_out: assert property (@(posedge clk) disable iff (!rst_n)
    !(state_q == RUN && mplier_q[0] && sum_c_out));

endmodule

// File: tb/tb_seq_mul_32.sv
// tb/tb_seq_mul_32.sv - directed and randomised self-checking bench for seq_mul_32

module tb_seq_mul_32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;

  int n_cmp;
  int n_err;

  seq_mul_32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; returns with the accept edge just passed.
  task automatic accept(input logic [31:0] aa, input logic [31:0] bb, output bit timeout);
    int n;
    n = 0;
    timeout = 1'b0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) timeout = 1'b1;
    in_valid = 1'b1;
    a = aa;
    b = bb;
    tick();
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // Count edges after the accept edge until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic complete();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 32'd0;
    b = 32'd0;
    tick();
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (product !== 64'd0) begin n_err++; $display("FAIL reset_product got %h want 0", product); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit to;
    int lat;
    accept(32'd3, 32'd5, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL basic_accept timeout got 1 want 0"); end
    wait_done(lat);
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL basic_latency got %0d want 32", lat); end
    n_cmp++; if (product !== 64'h000000000000000F) begin n_err++; $display("FAIL basic_product got %h want f", product); end
    complete();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready_after got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_out_valid_after got %b want 0", out_valid); end
  endtask

  task automatic test_max();
    bit to;
    int lat;
    accept(32'hFFFFFFFF, 32'hFFFFFFFF, to);
    wait_done(lat);
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL max_latency got %0d want 32", lat); end
    n_cmp++; if (product !== 64'hFFFFFFFE00000001) begin n_err++; $display("FAIL max_product got %h want fffffffe00000001", product); end
    complete();
  endtask

  task automatic test_zero();
    bit to;
    int lat;
    accept(32'd0, 32'h12345678, to);
    wait_done(lat);
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL zero_a_latency got %0d want 32", lat); end
    n_cmp++; if (product !== 64'd0) begin n_err++; $display("FAIL zero_a_product got %h want 0", product); end
    complete();
    accept(32'h12345678, 32'd0, to);
    wait_done(lat);
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL zero_b_latency got %0d want 32", lat); end
    n_cmp++; if (product !== 64'd0) begin n_err++; $display("FAIL zero_b_product got %h want 0", product); end
    complete();
  endtask

  task automatic test_backpressure();
    bit to;
    int spurious;
    accept(32'h10000, 32'h10000, to);
    for (int i = 0; i < 32; i++) begin
      in_valid = (i % 5 == 0);
      a = 32'd7;
      b = 32'd7;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_latency out_valid got %b want 1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 32'd7;
      b = 32'd7;
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid cycle %0d got %b want 1", i, out_valid); end
      n_cmp++; if (product !== 64'h0000000100000000) begin n_err++; $display("FAIL bp_hold_product cycle %0d got %h want 100000000", i, product); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0;
    complete();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release in_ready got %b want 1", in_ready); end
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) spurious++;
    end
    n_cmp++; if (spurious !== 0) begin n_err++; $display("FAIL bp_ignored_operands out_valid cycles got %0d want 0", spurious); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int lat;
    accept(32'd9, 32'd9, to);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    n_cmp++; if (product !== 64'd0) begin n_err++; $display("FAIL midrst_product got %h want 0", product); end
    accept(32'd6, 32'd7, to);
    wait_done(lat);
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL midrst_latency got %0d want 32", lat); end
    n_cmp++; if (product !== 64'd42) begin n_err++; $display("FAIL midrst_product_after got %h want 2a", product); end
    complete();
  endtask

  task automatic test_back_to_back();
    int edges[$];
    int e;
    bit pre;
    e = 0;
    in_valid = 1'b1;
    a = 32'd11;
    b = 32'd13;
    out_ready = 1'b1;
    while (edges.size() < 3 && e < 200) begin
      pre = in_ready;
      tick();
      e++;
      if (pre) edges.push_back(e);
      if (out_valid) begin
        n_cmp++; if (product !== 64'd143) begin n_err++; $display("FAIL b2b_product got %h want 8f", product); end
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (edges.size() != 3) begin
      n_err++; $display("FAIL b2b_accepts got %0d want 3", edges.size());
    end else begin
      n_cmp++; if (edges[1] - edges[0] !== 34) begin n_err++; $display("FAIL b2b_spacing1 got %0d want 34", edges[1] - edges[0]); end
      n_cmp++; if (edges[2] - edges[1] !== 34) begin n_err++; $display("FAIL b2b_spacing2 got %0d want 34", edges[2] - edges[1]); end
    end
    repeat (40) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    bit to;
    int lat;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] exp;
    int bad;
    int done_cnt;
    bad = 0;
    done_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      ra = $urandom;
      rb = $urandom;
      if (i % 10 == 0) ra = 32'hFFFFFFFF;
      exp = {32'd0, ra} * {32'd0, rb};
      accept(ra, rb, to);
      wait_done(lat);
      if (lat == 32 && out_valid) done_cnt++;
      repeat ($urandom_range(0, 3)) tick();
      if (product !== exp || out_valid !== 1'b1) begin
        bad++;
        if (bad <= 5) $display("FAIL rand_product #%0d a=%h b=%h got %h want %h", i, ra, rb, product, exp);
      end
      complete();
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rand_bad_count got %0d want 0", bad); end
    n_cmp++; if (done_cnt !== 1000) begin n_err++; $display("FAIL rand_transactions got %0d want 1000", done_cnt); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_mul_32.md
# seq_mul_32

Iterative 32x32 -> 64-bit unsigned shift-and-add multiplier built around a single csa_64 instance as its accumulation adder. It sits directly upstream of the 64-bit add path: it accepts operand pairs on a valid/ready handshake, performs one conditional add per cycle, and presents the 64-bit product on a second valid/ready handshake. Throughput is one product per 34 cycles; there is no operand or result buffering beyond one in-flight operation.

## Interface
- Parameters: none. Widths are fixed at 32x32 -> 64 to match csa_64.
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset; synchronous, active-low
- in_valid  input  1  operand pair a/b valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  32  multiplicand, unsigned
- b  input  32  multiplier, unsigned
- out_valid  output  1  product valid (high only in DONE)
- out_ready  input  1  consumer accepts product
- product  output  64  a*b, unsigned, exact

## Operation
- State machine: IDLE, RUN, DONE.
- Registers: mcand[63:0], mplier[31:0], acc[63:0], cnt[5:0], state.
- IDLE: in_ready=1. On in_valid && in_ready at a rising edge: mcand <= {32'b0, a}, mplier <= b, acc <= 0, cnt <= 0, state <= RUN.
- RUN: each edge performs one iteration:
  - if mplier[0]: acc <= csa_64 sum of (acc, mcand, c_in=0); else acc unchanged.
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - on the edge where cnt == 31 (32nd iteration): state <= DONE.
- Fixed 32 iterations regardless of operand values; no early termination on mplier == 0.
- csa_64 c_out is unused; with 32-bit operands acc never exceeds 2^64-1, so c_out must be 0 in every iteration (assertion point for verification).
- DONE: out_valid=1, product = acc, held stable. On out_valid && out_ready: state <= IDLE.
- in_valid while in RUN or DONE is ignored (in_ready=0); a/b are sampled only at the accept edge, so they may change afterwards.
- product output is driven from acc in all states; it is only meaningful while out_valid=1.

## Timing
- Reset (rst_n=0 at a rising edge): state <= IDLE, acc <= 0, mcand <= 0, mplier <= 0, cnt <= 0. After reset: in_ready=1, out_valid=0, product=0.
- Reset has priority over every other event, including an accept edge or a completion edge. Reset mid-RUN or in DONE discards the operation with no output.
- Accept at edge E0 -> out_valid rises after edge E32 (32 cycles of RUN). Product is valid in the cycle following E32.
- Completion at edge Ek (out_valid && out_ready) -> IDLE; in_ready=1 in the following cycle; the earliest next accept is edge Ek+1. The minimum accept-to-accept spacing is 34 edges.
- out_ready low in DONE: out_valid and product hold indefinitely, and no new operands are accepted.
- in_ready and out_valid are pure state decodes (registered state, no combinational path from in_valid/out_ready).
- Critical path: one csa_64 carry chain plus the acc mux, within one cycle.

## Test plan
- Reset, then a=3, b=5 accepted at E0, out_ready=1 -> out_valid rises after E32, product=0x000000000000000F, in_ready=1 one cycle after completion.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFE00000001; csa_64 c_out is 0 on all 32 iterations.
- a=0, b=0x12345678 and a=0x12345678, b=0 -> product=0, latency still exactly 32 cycles.
- Backpressure: a=0x10000, b=0x10000, out_ready=0 for 10 cycles in DONE -> out_valid stays 1, product=0x0000000100000000 stable, in_ready=0, and in_valid pulses with a=7, b=7 during RUN/DONE are ignored (the next product is not 49 unless re-presented).
- Reset mid-operation: assert rst_n=0 at iteration 10 -> next cycle out_valid=0, in_ready=1, product=0; a subsequent a=6, b=7 yields 42 with normal latency.
- Randomised: 1000 random a/b pairs with random out_ready and in_valid gaps -> every product equals the 64-bit reference a*b, with no lost or duplicated transactions.
